// File: rtl/bitty_fetch_ctrl.sv
// bitty_fetch_ctrl
//
// Instruction sequencer in front of the bitty core. It walks the program
// counter from a start address to an inclusive end address, wrapping modulo
// 2^ADDR_W. For each instruction it:
//   - reads the word from a synchronous program memory,
//   - presents it to bitty on d_instr with run held high,
//   - waits for done and captures d_out,
//   - counts the retired instruction.
// A watchdog moves the block to ERROR if bitty never signals done. abort
// returns the block to IDLE from any state.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, abort          begin a program / return to idle
//   start_addr, end_addr  program range, sampled with start
//   mem_addr, mem_rd      program-memory read request
//   mem_data              read data, valid the cycle after mem_rd
//   d_instr, run          instruction and run level to bitty
//   done, d_out           completion and result from bitty
//   result                d_out captured on done
//   pc                    address of the current instruction
//   retired               instructions completed since start (wraps)
//   busy, halted, error   status flags

module bitty_fetch_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_data,
    output logic [15:0]       d_instr,
    output logic              run,
    input  logic              done,
    input  logic [15:0]       d_out,
    output logic [15:0]       result,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       retired,
    output logic              busy,
    output logic              halted,
    output logic              error
);

    localparam int WAIT_W = $clog2(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_RETIRE,
        S_HALT,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       d_instr_q, d_instr_d;
    logic [15:0]       result_q, result_d;
    logic [15:0]       retired_q, retired_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            end_q      <= '0;
            mem_addr_q <= '0;
            d_instr_q  <= '0;
            result_q   <= '0;
            retired_q  <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            end_q      <= end_d;
            mem_addr_q <= mem_addr_d;
            d_instr_q  <= d_instr_d;
            result_q   <= result_d;
            retired_q  <= retired_d;
            wait_q     <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        end_d      = end_q;
        mem_addr_d = mem_addr_q;
        d_instr_d  = d_instr_q;
        result_d   = result_q;
        retired_d  = retired_q;
        wait_d     = wait_q;

        // abort outranks start, so it also blocks a restart from HALT/ERROR
        // and leaves every datapath register untouched.
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_HALT, S_ERROR: begin
                    if (start) begin
                        pc_d       = start_addr;
                        end_d      = end_addr;
                        retired_d  = '0;
                        // The read address is loaded on entry to FETCH, so
                        // it equals pc during FETCH and holds afterwards.
                        mem_addr_d = start_addr;
                        state_d    = S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_d = S_LOAD;
                end
                S_LOAD: begin
                    d_instr_d = mem_data;
                    wait_d    = '0;
                    state_d   = S_EXEC;
                end
                S_EXEC: begin
                    // done is checked first so it wins over the last
                    // watchdog cycle.
                    if (done) begin
                        result_d = d_out;
                        state_d  = S_RETIRE;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = S_ERROR;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                S_RETIRE: begin
                    retired_d = retired_q + 16'd1;
                    if (pc_q == end_q) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d       = pc_q + ADDR_W'(1);
                        mem_addr_d = pc_q + ADDR_W'(1);
                        state_d    = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_rd   = (state_q == S_FETCH);
    assign run      = (state_q == S_EXEC);
    assign d_instr  = d_instr_q;
    assign result   = result_q;
    assign pc       = pc_q;
    assign retired  = retired_q;
    assign busy     = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                      (state_q == S_EXEC)  || (state_q == S_RETIRE);
    assign halted   = (state_q == S_HALT);
    assign error    = (state_q == S_ERROR);

endmodule

// File: tb/tb_bitty_fetch_ctrl.sv
// Directed testbench for bitty_fetch_ctrl (ADDR_W=8, MAX_WAIT=8).
// A synchronous program memory is modelled here, and bitty's done/d_out
// are driven by hand from each test step.

module tb_bitty_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  start_addr = '0;
    logic [7:0]  end_addr = '0;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data = '0;
    logic [15:0] d_instr;
    logic        run;
    logic        done = 1'b0;
    logic [15:0] d_out = '0;
    logic [15:0] result;
    logic [7:0]  pc;
    logic [15:0] retired;
    logic        busy;
    logic        halted;
    logic        error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;

    logic [15:0] mem [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    bitty_fetch_ctrl #(.ADDR_W(8), .MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .start_addr(start_addr), .end_addr(end_addr),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .d_instr(d_instr), .run(run), .done(done), .d_out(d_out),
        .result(result), .pc(pc), .retired(retired),
        .busy(busy), .halted(halted), .error(error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge (FETCH).
    task automatic go(input logic [7:0] a, input logic [7:0] b);
        start_addr = a;
        end_addr   = b;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    // One full instruction; done is raised in the lat-th EXEC cycle.
    // Returns at the negedge inside RETIRE.
    task automatic do_instr(input int lat, input logic [15:0] dout,
                            input logic [7:0] exp_addr, input logic [15:0] exp_instr);
        int n = 0;
        while (!mem_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_seen", {31'd0, mem_rd}, 32'd1);
        chk("mem_addr", {24'd0, mem_addr}, {24'd0, exp_addr});
        @(negedge clk);
        @(negedge clk);
        chk("d_instr", {16'd0, d_instr}, {16'd0, exp_instr});
        for (int i = 1; i <= lat; i++) begin
            if (i > 1) @(negedge clk);
            chk("run_hi", {31'd0, run}, 32'd1);
            if (i == lat) begin
                done  = 1'b1;
                d_out = dout;
            end
        end
        @(negedge clk);
        done = 1'b0;
        chk("run_fall", {31'd0, run}, 32'd0);
        chk("result", {16'd0, result}, {16'd0, dout});
        $display("instr addr=0x%02h instr=0x%04h lat=%0d result=0x%04h retired=%0d",
                 exp_addr, d_instr, lat, result, retired);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3 + 16'h0100);
        mem[8'h05] = 16'h1234;
        mem[8'h10] = 16'hA001; mem[8'h11] = 16'hA002; mem[8'h12] = 16'hA003;
        mem[8'hFE] = 16'hC0FE; mem[8'hFF] = 16'hC0FF;
        mem[8'h00] = 16'hC000; mem[8'h01] = 16'hC001;
        mem[8'h40] = 16'h4040; mem[8'h80] = 16'h8080;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_outs", {busy, halted, error, run, mem_rd, pc, mem_addr},
            {5'b0, 8'h00, 8'h00});
        chk("rst_data", {d_instr, result}, 32'd0);
        chk("rst_retired", {16'd0, retired}, 32'd0);

        // 1: single instruction at 0x05
        go(8'h05, 8'h05);
        do_instr(2, 16'hBEEF, 8'h05, 16'h1234);
        @(negedge clk);
        chk("t1_halted", {31'd0, halted}, 32'd1);
        chk("t1_retired", {16'd0, retired}, 32'd1);
        chk("t1_pc", {24'd0, pc}, 32'h05);
        chk("t1_busy", {31'd0, busy}, 32'd0);

        // 2: 0x10-0x12, latencies 1,4,2 -> 16 cycles
        go(8'h10, 8'h12);
        do_instr(1, 16'h1111, 8'h10, 16'hA001);
        do_instr(4, 16'h2222, 8'h11, 16'hA002);
        do_instr(2, 16'h3333, 8'h12, 16'hA003);
        @(negedge clk);
        chk("t2_cycles", cyc - t0, 32'd16);
        chk("t2_halted", {31'd0, halted}, 32'd1);
        chk("t2_retired", {16'd0, retired}, 32'd3);
        chk("t2_result", {16'd0, result}, 32'h3333);

        // 3: watchdog, done never asserted
        go(8'h20, 8'h20);
        n = 0;
        while (!run && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (run && n < 20) begin @(negedge clk); n++; end
        chk("t3_run_cycles", n, 32'd8);
        chk("t3_flags", {29'd0, error, busy, run}, 32'b100);
        go(8'h05, 8'h05);
        do_instr(1, 16'h0F0F, 8'h05, 16'h1234);
        @(negedge clk);
        chk("t3_restart", {29'd0, halted, error, busy}, 32'b100);
        chk("t3_retired", {16'd0, retired}, 32'd1);

        // 4: wrap-around 0xFE..0x01
        go(8'hFE, 8'h01);
        do_instr(1, 16'h0001, 8'hFE, 16'hC0FE);
        do_instr(2, 16'h0002, 8'hFF, 16'hC0FF);
        do_instr(1, 16'h0003, 8'h00, 16'hC000);
        do_instr(3, 16'h0004, 8'h01, 16'hC001);
        @(negedge clk);
        chk("t4_retired", {16'd0, retired}, 32'd4);
        chk("t4_halted", {31'd0, halted}, 32'd1);

        // 5: abort in 3rd EXEC cycle of instruction 2
        go(8'h30, 8'h32);
        do_instr(1, 16'h5555, 8'h30, mem[8'h30]);
        @(negedge clk);
        chk("t5_fetch2", {23'd0, mem_rd, mem_addr}, {23'd0, 1'b1, 8'h31});
        repeat (4) @(negedge clk);
        chk("t5_exec3", {31'd0, run}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_idle", {28'd0, run, busy, halted, error}, 32'd0);
        chk("t5_retired", {16'd0, retired}, 32'd1);
        done = 1'b1; d_out = 16'hDEAD;
        @(negedge clk);
        done = 1'b0;
        chk("t5_late_done", {16'd0, result}, 32'h5555);
        chk("t5_late_ret", {16'd0, retired}, 32'd1);
        start = 1'b1; abort = 1'b1; start_addr = 8'h60; end_addr = 8'h60;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("t5_start_abort", {30'd0, busy, mem_rd}, 32'd0);
        chk("t5_pc_kept", {24'd0, pc}, 32'h31);

        // 6: start ignored while busy, then reset mid-EXEC
        go(8'h40, 8'h41);
        chk("t6_fetch", {23'd0, mem_rd, mem_addr}, {23'd0, 1'b1, 8'h40});
        start = 1'b1; start_addr = 8'h80; end_addr = 8'h80;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t6_pc_busy", {24'd0, pc}, 32'h40);
        chk("t6_instr_busy", {16'd0, d_instr}, 32'h4040);
        @(negedge clk);
        chk("t6_exec2", {31'd0, run}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_rst_flags", {27'd0, run, busy, halted, error, mem_rd}, 32'd0);
        chk("t6_rst_regs", {pc, mem_addr, retired}, 32'd0);
        chk("t6_rst_data", {d_instr, result}, 32'd0);

        // done coincident with the final watchdog cycle
        go(8'h50, 8'h50);
        do_instr(8, 16'h7777, 8'h50, mem[8'h50]);
        @(negedge clk);
        chk("t6_wd_done", {29'd0, halted, error, busy}, 32'b100);
        chk("t6_wd_ret", {16'd0, retired}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
